// File: rtl/muldiv_scheduler.sv
// HI/LO multiply/divide sequencer beside the E-stage ALU: computes the 64-bit result
// at issue, holds it for a fixed countdown, then commits it to HI/LO.
module muldiv_scheduler #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_op_valid,
  input  logic [2:0]  i_op,
  input  logic [31:0] i_rs,
  input  logic [31:0] i_rt,
  input  logic        i_d_use_md,
  output logic        o_busy,
  output logic        o_stall,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t      r_state, w_state_next;
  logic [3:0]  r_cnt, w_cnt_next;
  logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
  logic        r_pend_ok;

  logic        w_idle, w_start, w_mt, w_commit;
  logic [3:0]  w_n;
  logic [63:0] w_rs_sx, w_rt_sx, w_prod_s, w_prod_u;
  logic        w_div_signed, w_rs_neg, w_rt_neg;
  logic [31:0] w_rs_mag, w_rt_mag, w_rt_div, w_q, w_r, w_quo, w_rem;
  logic [63:0] w_result;

  assign w_idle   = (r_state == S_IDLE);
  assign w_start  = i_op_valid & (i_op <= 3'd3) & w_idle;
  assign w_mt     = i_op_valid & ((i_op == 3'd4) | (i_op == 3'd5)) & w_idle;
  assign w_n      = i_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
  assign w_commit = (r_state == S_RUN) & (r_cnt == 4'd1);

  // Low 64 bits of the product of sign-extended operands equal the signed product.
  assign w_rs_sx  = {{32{i_rs[31]}}, i_rs};
  assign w_rt_sx  = {{32{i_rt[31]}}, i_rt};
  assign w_prod_s = w_rs_sx * w_rt_sx;
  assign w_prod_u = {32'd0, i_rs} * {32'd0, i_rt};

  // Signed divide on magnitudes avoids the MIN/-1 overflow; divisor forced nonzero
  // since a zero-divide result is never committed.
  assign w_div_signed = ~i_op[0];
  assign w_rs_neg     = w_div_signed & i_rs[31];
  assign w_rt_neg     = w_div_signed & i_rt[31];
  assign w_rs_mag     = w_rs_neg ? (32'd0 - i_rs) : i_rs;
  assign w_rt_mag     = w_rt_neg ? (32'd0 - i_rt) : i_rt;
  assign w_rt_div     = (w_rt_mag == 32'd0) ? 32'd1 : w_rt_mag;
  assign w_q          = w_rs_mag / w_rt_div;
  assign w_r          = w_rs_mag % w_rt_div;
  assign w_quo        = (w_rs_neg ^ w_rt_neg) ? (32'd0 - w_q) : w_q;
  assign w_rem        = w_rs_neg ? (32'd0 - w_r) : w_r;

  always_comb begin
    w_result = {w_rem, w_quo};
    case (i_op)
      3'd0:    w_result = w_prod_s;
      3'd1:    w_result = w_prod_u;
      default: w_result = {w_rem, w_quo};
    endcase
  end

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_state_next = S_RUN;
          w_cnt_next   = w_n;
        end
      end
      S_RUN: begin
        w_cnt_next = r_cnt - 4'd1;
        if (r_cnt == 4'd1) w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= 4'd0;
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_pend_ok <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      if (w_start) begin
        r_pend_hi <= w_result[63:32];
        r_pend_lo <= w_result[31:0];
        r_pend_ok <= ~(i_op[1] & (i_rt == 32'd0));
      end
      if (w_commit && r_pend_ok) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end else if (w_mt) begin
        if (i_op == 3'd4) r_hi <= i_rs;
        else              r_lo <= i_rs;
      end
    end
  end

  assign o_busy  = (r_state == S_RUN);
  assign o_done  = w_commit;
  assign o_stall = i_d_use_md & (o_busy | w_start);
  assign o_hi    = r_hi;
  assign o_lo    = r_lo;

endmodule

// File: tb/tb_muldiv_scheduler.sv
// Randomized bench for muldiv_scheduler against a cycle-level model built from
// 64-bit arithmetic and a remaining-busy-cycle counter.
module tb_muldiv_scheduler;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        i_clk = 1'b0;
  logic        i_reset = 1'b0;
  logic        i_op_valid = 1'b0;
  logic [2:0]  i_op = 3'd7;
  logic [31:0] i_rs = 32'd0;
  logic [31:0] i_rt = 32'd0;
  logic        i_d_use_md = 1'b0;
  logic        o_busy, o_stall, o_done;
  logic [31:0] o_hi, o_lo;

  muldiv_scheduler #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_op_valid(i_op_valid), .i_op(i_op),
    .i_rs(i_rs), .i_rt(i_rt), .i_d_use_md(i_d_use_md),
    .o_busy(o_busy), .o_stall(o_stall), .o_done(o_done), .o_hi(o_hi), .o_lo(o_lo)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;

  // Model: cycles of busy still to come, pending result and architectural HI/LO.
  int          m_left = 0;
  logic [31:0] m_hi = 0, m_lo = 0, m_phi = 0, m_plo = 0;
  bit          m_pok = 0;
  int          busy_seen;
  bit          done_seen;
  bit          stall_seen;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic void compute(input logic [2:0] op, input logic [31:0] rs,
                                  input logic [31:0] rt, output bit ok,
                                  output logic [31:0] hi, output logic [31:0] lo);
    longint a, b, q, r, p;
    longint unsigned pu;
    ok = 1; hi = 0; lo = 0;
    case (op)
      3'd0: begin
        a = longint'($signed(rs)); b = longint'($signed(rt)); p = a * b;
        hi = p[63:32]; lo = p[31:0];
      end
      3'd1: begin
        pu = longint'(rs) * longint'(rt);
        hi = pu[63:32]; lo = pu[31:0];
      end
      3'd2, 3'd3: begin
        if (rt == 0) ok = 0;
        else begin
          if (op == 3'd2) begin a = longint'($signed(rs)); b = longint'($signed(rt)); end
          else begin a = longint'(rs); b = longint'(rt); end
          q = a / b; r = a % b;
          lo = q[31:0]; hi = r[31:0];
        end
      end
      default: ok = 1;
    endcase
  endfunction

  task automatic model_reset();
    m_left = 0; m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_pok = 0;
  endtask

  task automatic model_edge();
    if (i_reset) return;
    if (m_left > 0) begin
      m_left--;
      if (m_left == 0 && m_pok) begin m_hi = m_phi; m_lo = m_plo; end
    end else if (i_op_valid) begin
      if (i_op <= 3) begin
        compute(i_op, i_rs, i_rt, m_pok, m_phi, m_plo);
        m_left = (i_op >= 2) ? DC : MC;
        $display("op=%0d rs=0x%08h rt=0x%08h -> hi=0x%08h lo=0x%08h ok=%0d",
                 i_op, i_rs, i_rt, m_phi, m_plo, m_pok);
      end else if (i_op == 4) begin
        m_hi = i_rs;
        $display("op=4 MTHI rs=0x%08h", i_rs);
      end else if (i_op == 5) begin
        m_lo = i_rs;
        $display("op=5 MTLO rs=0x%08h", i_rs);
      end
    end
  endtask

  // One cycle: compare outputs just after the falling edge, then advance the model.
  task automatic tick();
    bit start;
    #1;
    start = i_op_valid && (i_op <= 3) && (m_left == 0);
    chk("busy",  {31'd0, o_busy},  {31'd0, m_left > 0});
    chk("done",  {31'd0, o_done},  {31'd0, m_left == 1});
    chk("stall", {31'd0, o_stall}, {31'd0, i_d_use_md && (m_left > 0 || start)});
    chk("hi", o_hi, m_hi);
    chk("lo", o_lo, m_lo);
    if (o_busy) busy_seen++;
    if (o_done) done_seen = 1;
    if (o_stall) stall_seen = 1;
    @(posedge i_clk);
    model_edge();
    @(negedge i_clk);
  endtask

  task automatic run_to_idle();
    int guard = 0;
    while (m_left > 0 && guard < 40) begin tick(); guard++; end
    if (m_left > 0) begin
      errors++; checks++;
      $display("FAIL timeout: busy still pending after %0d cycles", guard);
    end
  endtask

  task automatic issue(input logic [2:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic dum);
    i_op_valid = 1; i_op = op; i_rs = rs; i_rt = rt; i_d_use_md = dum;
    busy_seen = 0; done_seen = 0; stall_seen = 0;
    tick();
    i_op_valid = 0; i_op = 3'd7;
  endtask

  task automatic after_checks(input int n_busy, input logic [31:0] hi, input logic [31:0] lo);
    #1;
    chk("busy_len", busy_seen, n_busy);
    chk("hi_lit", o_hi, hi);
    chk("lo_lit", o_lo, lo);
    chk("busy_after", {31'd0, o_busy}, 32'd0);
  endtask

  logic [31:0] corners [6];
  function automatic logic [31:0] pick();
    int k = $urandom_range(0, 9);
    if (k < 5) return corners[k];
    return $urandom;
  endfunction

  initial begin
    corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFFFFFF;
    corners[3] = 32'h80000000; corners[4] = 32'h7FFFFFFF; corners[5] = 32'h2;

    i_reset = 1; model_reset();
    @(negedge i_clk);
    tick();
    chk("rst_hi", o_hi, 32'h0);
    chk("rst_busy", {31'd0, o_busy}, 32'd0);
    i_reset = 0;
    tick();

    // MULT with D-stage hazard held the whole time
    issue(3'd0, 32'hFFFFFFFE, 32'd3, 1'b1);
    chk("stall_start", {31'd0, stall_seen}, 32'd1);
    run_to_idle();
    after_checks(5, 32'hFFFFFFFF, 32'hFFFFFFFA);
    chk("done_mult", {31'd0, done_seen}, 32'd1);
    chk("stall_after", {31'd0, o_stall}, 32'd0);
    tick();
    i_d_use_md = 0;

    issue(3'd1, 32'hFFFFFFFE, 32'd3, 1'b0);
    run_to_idle();
    after_checks(5, 32'h00000002, 32'hFFFFFFFA);
    tick();

    issue(3'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    run_to_idle();
    after_checks(10, 32'hFFFFFFFF, 32'hFFFFFFFD);
    tick();

    issue(3'd4, 32'h11, 32'd0, 1'b0);
    issue(3'd5, 32'h22, 32'd0, 1'b0);
    issue(3'd3, 32'd7, 32'd0, 1'b0);
    run_to_idle();
    after_checks(10, 32'h11, 32'h22);
    chk("done_div0", {31'd0, done_seen}, 32'd1);
    tick();

    issue(3'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    run_to_idle();
    after_checks(10, 32'h0, 32'h80000000);
    tick();

    // Reset during the third busy cycle of a DIV
    issue(3'd2, 32'd100, 32'd3, 1'b0);
    tick(); tick();
    i_reset = 1; model_reset();
    #1;
    chk("rst_mid_busy", {31'd0, o_busy}, 32'd0);
    chk("rst_mid_hi", o_hi, 32'h0);
    chk("rst_mid_lo", o_lo, 32'h0);
    tick();
    i_reset = 0;
    tick();
    issue(3'd0, 32'd6, 32'd7, 1'b0);
    run_to_idle();
    after_checks(5, 32'h0, 32'd42);
    tick();

    // Randomized traffic, including ops issued while busy and occasional resets
    for (int n = 0; n < 1500; n++) begin
      i_op_valid = ($urandom_range(0, 2) != 0);
      i_op       = 3'($urandom_range(0, 7));
      i_rs       = pick();
      i_rt       = pick();
      i_d_use_md = $urandom_range(0, 1);
      if ($urandom_range(0, 299) == 0) begin
        i_op_valid = 0; i_reset = 1; model_reset();
        tick();
        i_reset = 0;
      end
      tick();
    end
    i_op_valid = 0;
    run_to_idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
